// File: rtl/seg_scan_mux_if.sv
// ============================================================================
// Module  : seg_scan_mux_if
// Brief   : Pattern inputs, enable and multiplexed display outputs of the
//           seven-segment scan multiplexer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_scan_mux_if;
    logic       en;
    logic [7:0] seg0;
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic [7:0] seg_out;
    logic [2:0] dig_sel;
    logic       frame_start;

    modport master (
        output en,
        output seg0,
        output seg1,
        output seg2,
        input  seg_out,
        input  dig_sel,
        input  frame_start
    );

    modport slave (
        input  en,
        input  seg0,
        input  seg1,
        input  seg2,
        output seg_out,
        output dig_sel,
        output frame_start
    );
endinterface

`default_nettype wire

// File: rtl/seg_scan_mux.sv
// ============================================================================
// Module  : seg_scan_mux
// Brief   : Time-multiplexes three 7-segment patterns onto one shared bus with
//           per-slot blanking and a once-per-frame input snapshot.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_mux #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLANK_CYC = 10,
    parameter int SEG_POL   = 1,
    parameter int DIG_POL   = 1
) (
    input  wire             clk,
    input  wire             rst,
    seg_scan_mux_if.slave   bus
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [CNT_W-1:0] c_CNT_MAX   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] c_BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [7:0]       c_SEG_BLANK = (SEG_POL != 0) ? 8'h00 : 8'hFF;
    localparam logic [2:0]       c_DIG_BLANK = (DIG_POL != 0) ? 3'b000 : 3'b111;
    localparam logic [7:0]       c_SEG_XOR   = (SEG_POL != 0) ? 8'h00 : 8'hFF;
    localparam logic [2:0]       c_DIG_XOR   = (DIG_POL != 0) ? 3'b000 : 3'b111;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       snap0_q, snap0_d;
    logic [7:0]       snap1_q, snap1_d;
    logic [7:0]       snap2_q, snap2_d;
    logic [7:0]       seg_out_q, seg_out_d;
    logic [2:0]       dig_sel_q, dig_sel_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       pattern;

    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap0_d       = snap0_q;
        snap1_d       = snap1_q;
        snap2_d       = snap2_q;
        pattern       = 8'h00;
        seg_out_d     = c_SEG_BLANK;
        dig_sel_d     = c_DIG_BLANK;
        frame_start_d = 1'b0;

        if (cnt_q == c_CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        // Outputs reflect the state being entered, so the snapshot taken at
        // the frame edge is what the first slot of that frame shows.
        if ((cnt_d == '0) && (idx_d == 2'd0)) begin
            frame_start_d = 1'b1;
            snap0_d       = bus.seg0;
            snap1_d       = bus.seg1;
            snap2_d       = bus.seg2;
        end

        case (idx_d)
            2'd0:    pattern = snap0_d;
            2'd1:    pattern = snap1_d;
            default: pattern = snap2_d;
        endcase

        if (bus.en && (cnt_d >= c_BLANK_END)) begin
            seg_out_d = pattern ^ c_SEG_XOR;
            dig_sel_d = (3'b001 << idx_d) ^ c_DIG_XOR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= c_CNT_MAX;
            idx_q         <= 2'd2;
            snap0_q       <= 8'h00;
            snap1_q       <= 8'h00;
            snap2_q       <= 8'h00;
            seg_out_q     <= c_SEG_BLANK;
            dig_sel_q     <= c_DIG_BLANK;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap0_q       <= snap0_d;
            snap1_q       <= snap1_d;
            snap2_q       <= snap2_d;
            seg_out_q     <= seg_out_d;
            dig_sel_q     <= dig_sel_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg_out     = seg_out_q;
    assign bus.dig_sel     = dig_sel_q;
    assign bus.frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
// ============================================================================
// Module  : tb_seg_scan_mux
// Brief   : Directed self-checking bench for seg_scan_mux (active-high and
//           inverted-polarity instances, SCAN_DIV=8, BLANK_CYC=2).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg_scan_mux_if ifm ();
    seg_scan_mux_if ifp ();

    seg_scan_mux #(.SCAN_DIV(8), .BLANK_CYC(2), .SEG_POL(1), .DIG_POL(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ifm)
    );

    seg_scan_mux #(.SCAN_DIV(8), .BLANK_CYC(2), .SEG_POL(0), .DIG_POL(0)) u_dut_pol (
        .clk (clk),
        .rst (rst),
        .bus (ifp)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle; inputs changed after this apply at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected active-high outputs for cycle c (c=1 is the first cycle after reset release).
    function automatic void expect_at(input int c, input logic [7:0] p0, input logic [7:0] p1,
                                      input logic [7:0] p2, output logic [7:0] s,
                                      output logic [2:0] d, output logic fs);
        int p, slot, cn;
        p    = (c - 1) % 24;
        slot = p / 8;
        cn   = p % 8;
        fs   = (p == 0);
        if (cn < 2) begin
            s = 8'h00;
            d = 3'b000;
        end else begin
            s = (slot == 0) ? p0 : (slot == 1) ? p1 : p2;
            d = 3'(1 << slot);
        end
    endfunction

    task automatic start_run(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        rst      = 1'b1;
        ifm.en   = 1'b1;
        ifm.seg0 = a;
        ifm.seg1 = b;
        ifm.seg2 = c;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ifm.en   = 1'($urandom);
            ifm.seg0 = 8'($urandom);
            ifm.seg1 = 8'($urandom);
            ifm.seg2 = 8'($urandom);
            ifp.en   = 1'b1;
            ifp.seg0 = 8'($urandom);
            ifp.seg1 = 8'($urandom);
            ifp.seg2 = 8'($urandom);
            step();
            checks++;
            if (ifm.seg_out !== 8'h00 || ifm.dig_sel !== 3'b000 || ifm.frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: seg=%h dig=%b fs=%b, expected 00/000/0",
                         i, ifm.seg_out, ifm.dig_sel, ifm.frame_start);
            end
            checks++;
            if (ifp.seg_out !== 8'hFF || ifp.dig_sel !== 3'b111 || ifp.frame_start !== 1'b0) begin
                errors++;
                $display("FAIL reset_pol[%0d]: seg=%h dig=%b fs=%b, expected FF/111/0",
                         i, ifp.seg_out, ifp.dig_sel, ifp.frame_start);
            end
        end
    endtask

    task automatic test_static_scan();
        logic [7:0] s;
        logic [2:0] d;
        logic       fs;
        start_run(8'h3F, 8'h06, 8'h5B);
        for (int c = 1; c <= 25; c++) begin
            step();
            expect_at(c, 8'h3F, 8'h06, 8'h5B, s, d, fs);
            checks++;
            if (ifm.seg_out !== s || ifm.dig_sel !== d || ifm.frame_start !== fs) begin
                errors++;
                $display("FAIL static c%0d: seg=%h dig=%b fs=%b, expected %h/%b/%b",
                         c, ifm.seg_out, ifm.dig_sel, ifm.frame_start, s, d, fs);
            end
        end
    endtask

    task automatic test_anti_tear();
        logic [7:0] s;
        logic [2:0] d;
        logic       fs;
        start_run(8'h3F, 8'h06, 8'h5B);
        for (int c = 1; c <= 40; c++) begin
            step();
            expect_at(c, 8'h3F, (c <= 24) ? 8'h06 : 8'h66, 8'h5B, s, d, fs);
            if ((c >= 11 && c <= 16) || (c >= 33)) begin
                checks++;
                if (ifm.seg_out !== s || ifm.dig_sel !== d || ifm.frame_start !== fs) begin
                    errors++;
                    $display("FAIL anti_tear c%0d: seg=%h dig=%b fs=%b, expected %h/%b/%b",
                             c, ifm.seg_out, ifm.dig_sel, ifm.frame_start, s, d, fs);
                end
            end
            if (c == 5) ifm.seg1 = 8'h66;
        end
    endtask

    task automatic test_enable();
        logic [7:0] s;
        logic [2:0] d;
        logic       fs;
        start_run(8'h3F, 8'h06, 8'h5B);
        for (int c = 1; c <= 25; c++) begin
            step();
            expect_at(c, 8'h3F, 8'h06, 8'h5B, s, d, fs);
            if (c >= 11 && c <= 13) begin
                s = 8'h00;
                d = 3'b000;
            end
            checks++;
            if (ifm.seg_out !== s || ifm.dig_sel !== d || ifm.frame_start !== fs) begin
                errors++;
                $display("FAIL enable c%0d: seg=%h dig=%b fs=%b, expected %h/%b/%b",
                         c, ifm.seg_out, ifm.dig_sel, ifm.frame_start, s, d, fs);
            end
            if (c == 10) ifm.en = 1'b0;
            if (c == 13) ifm.en = 1'b1;
        end
    endtask

    task automatic test_mid_reset();
        start_run(8'h3F, 8'h06, 8'h5B);
        for (int c = 1; c <= 11; c++) step();
        checks++;
        if (ifm.seg_out !== 8'h06 || ifm.dig_sel !== 3'b010) begin
            errors++;
            $display("FAIL mid_reset_pre: seg=%h dig=%b, expected 06/010", ifm.seg_out, ifm.dig_sel);
        end
        rst      = 1'b1;
        ifm.seg0 = 8'h6D;
        step();
        checks++;
        if (ifm.seg_out !== 8'h00 || ifm.dig_sel !== 3'b000 || ifm.frame_start !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_blank: seg=%h dig=%b fs=%b, expected 00/000/0",
                     ifm.seg_out, ifm.dig_sel, ifm.frame_start);
        end
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (ifm.frame_start !== (c == 1) ||
                ifm.seg_out !== ((c == 3) ? 8'h6D : 8'h00) ||
                ifm.dig_sel !== ((c == 3) ? 3'b001 : 3'b000)) begin
                errors++;
                $display("FAIL mid_reset_restart c%0d: seg=%h dig=%b fs=%b, expected %h/%b/%b",
                         c, ifm.seg_out, ifm.dig_sel, ifm.frame_start,
                         (c == 3) ? 8'h6D : 8'h00, (c == 3) ? 3'b001 : 3'b000, (c == 1));
            end
        end
    endtask

    task automatic test_polarity();
        logic [7:0] s;
        logic [2:0] d;
        rst      = 1'b1;
        ifp.en   = 1'b1;
        ifp.seg0 = 8'h3F;
        ifp.seg1 = 8'h06;
        ifp.seg2 = 8'h5B;
        step();
        rst = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            step();
            s = (c >= 3 && c <= 8) ? 8'hC0 : 8'hFF;
            d = (c >= 3 && c <= 8) ? 3'b110 : 3'b111;
            checks++;
            if (ifp.seg_out !== s || ifp.dig_sel !== d || ifp.frame_start !== (c == 1)) begin
                errors++;
                $display("FAIL polarity c%0d: seg=%h dig=%b fs=%b, expected %h/%b/%b",
                         c, ifp.seg_out, ifp.dig_sel, ifp.frame_start, s, d, (c == 1));
            end
        end
    endtask

    initial begin
        ifm.en   = 1'b1;
        ifm.seg0 = 8'h00;
        ifm.seg1 = 8'h00;
        ifm.seg2 = 8'h00;
        ifp.en   = 1'b1;
        ifp.seg0 = 8'h00;
        ifp.seg1 = 8'h00;
        ifp.seg2 = 8'h00;
        test_reset();
        test_static_scan();
        test_anti_tear();
        test_enable();
        test_mid_reset();
        test_polarity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_scan_mux.md
Name: seg_scan_mux

Overview:
- Downstream consumer of the three-digit seven-segment counter outputs (seg0/seg1/seg2, 8-bit patterns, bit=1 means lit).
- Time-multiplexes the three patterns onto one shared 8-bit segment bus plus three digit-select lines for a common-bus LED display.
- Inserts a blanking gap between digits to prevent ghosting.
- Snapshots all three inputs once per frame so a count change mid-frame never tears the displayed value.

Parameters:
- SCAN_DIV, 1000: clock cycles per digit slot; legal range >= 2.
- BLANK_CYC, 10: blank cycles at the start of each slot; legal range 1 <= BLANK_CYC < SCAN_DIV.
- SEG_POL, 1: 1 = segment output active-high; 0 = active-low (pattern inverted).
- DIG_POL, 1: 1 = digit select active-high; 0 = active-low.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- en  input  1  display enable; 0 forces blank output, scan timing keeps running
- seg0  input  8  ones-digit pattern, bit=1 lit
- seg1  input  8  tens-digit pattern, bit=1 lit
- seg2  input  8  hundreds-digit pattern, bit=1 lit
- seg_out  output  8  shared segment bus, polarity per SEG_POL
- dig_sel  output  3  one-hot digit select, bit i drives digit i, polarity per DIG_POL
- frame_start  output  1  one-cycle pulse in the first cycle of each frame

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State: slot counter cnt, width $clog2(SCAN_DIV), range 0..SCAN_DIV-1. Digit index idx, range 0..2. Snapshot registers snap0..snap2.
- All outputs are registered and update on the same edge as cnt/idx, as a function of the newly entered (cnt, idx). Latency from state to output is 0.
- Reset (rst=1 at an edge):
  - cnt <= SCAN_DIV-1, idx <= 2, snap0..2 <= 0.
  - seg_out <= blank, dig_sel <= none, frame_start <= 0.
  - Reset has priority over every other input.
- Blank levels: seg_out = 8'h00 if SEG_POL=1, else 8'hFF. dig_sel = 3'b000 if DIG_POL=1, else 3'b111.
- Advance, each non-reset edge:
  - If cnt = SCAN_DIV-1: cnt <= 0 and idx <= (idx = 2) ? 0 : idx+1.
  - Otherwise: cnt <= cnt+1, idx unchanged.
- Because of the reset values, the first non-reset edge enters (0,0), the start of a frame.
- Frame start, on the edge entering cnt=0, idx=0:
  - snap0/1/2 <= seg0/1/2, sampled at that edge.
  - frame_start <= 1. frame_start is 0 in every other cycle.
  - Inputs sampled at any other edge are ignored until the next frame.
- Output selection, for the entered (cnt, idx) and en sampled at the same edge:
  - en=0 or cnt < BLANK_CYC: blank levels.
  - Otherwise: seg_out = snap[idx], inverted when SEG_POL=0. dig_sel = one-hot(idx), inverted when DIG_POL=0.
- Slot and frame length: SCAN_DIV cycles per slot; frame period 3*SCAN_DIV cycles, exact and constant.
- en does not affect cnt, idx, snapshot loading or frame_start.
- No overlap: because BLANK_CYC >= 1, two digits are never selected in the same cycle, and a digit change always passes through blank.
- Reset mid-frame: outputs blank in the first cycle after the edge that samples rst=1. After release, a fresh frame begins with a new snapshot.

Test Plan:
(Scenarios 2-6 use SCAN_DIV=8, BLANK_CYC=2, SEG_POL=1, DIG_POL=1, en=1 unless stated. Cycle 1 = first cycle after the first edge with rst=0.)
1. Reset: hold rst=1 for 3 edges with arbitrary inputs -> seg_out=00, dig_sel=000, frame_start=0 throughout.
2. Static scan, seg0=3F, seg1=06, seg2=5B:
   - Cycle 1: frame_start=1.
   - Cycles 1-2 blank; cycles 3-8 output 3F/001.
   - Cycles 9-10 blank; cycles 11-16 output 06/010.
   - Cycles 17-18 blank; cycles 19-24 output 5B/100.
   - Cycle 25: next frame_start=1.
3. Anti-tear: change seg1 to 66 during cycle 5 -> cycles 11-16 still show 06; cycles 35-40 show 66/010.
4. Enable: en=0 sampled at the edges entering cycles 11-13 -> those cycles blank; cycle 14 shows 06/010; frame_start still at cycle 25.
5. Mid-frame reset: rst=1 sampled at the edge entering cycle 12 -> cycle 12 blank. After rst returns low, the first cycle has frame_start=1, then 2 blank cycles, then the new seg0 snapshot on dig_sel=001.
6. Polarity: SEG_POL=0, DIG_POL=0, seg0=3F -> blank cycles show FF/111; cycles 3-8 show C0/110.
